instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Wishbone bus master that sits directly upstream of the boot ROM.
- Generates sequential 32-bit word reads from a program counter and buffers the returned words in a small prefetch FIFO.
- Presents the buffered words to the decode stage over a valid/ready handshake.
- Supports a redirect input (branch/jump/trap) that flushes buffered instructions and restarts fetch at a new address.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- wishbone, interface (wishbone_if.master), -, classic Wishbone master.
  - Drives cyc, stb, we, sel[3:0], adr[31:0].
  - Samples dat_i[31:0] (slave to master) and ack.
- redirect_valid, input, 1, restart fetch at redirect_pc this cycle.
- redirect_pc, input, 32, new fetch address; bits [1:0] ignored (forced 0).
- instr_valid, output, 1, FIFO head holds a valid instruction.
- instr_ready, input, 1, decode accepts head this cycle.
- instr_data, output, 32, instruction word at FIFO head.
- instr_pc, output, 32, byte address of instr_data.

Behaviour:
- Reset (synchronous, any state) forces:
  - cyc=stb=we=0, sel=4'hF, adr=0.
  - FIFO empty, instr_valid=0, instr_data=0, instr_pc=0.
  - fetch_pc=RESET_PC, state=IDLE.
  - An in-progress bus cycle is abandoned; cyc drops on the reset cycle.
- we is always 0; sel is always 4'hF; adr is always word aligned.
- FSM states:
  - IDLE: cyc=stb=0. Move to FETCH when credit = FIFO_DEPTH - occupancy > 0 and redirect_valid=0.
  - FETCH: cyc=stb=1, adr=fetch_pc, held stable until ack.
    - On ack: push {fetch_pc, dat_i} into FIFO, fetch_pc += 4.
    - After ack: go to FETCH again (back-to-back) if space remains after this push, else IDLE.
  - DRAIN: entered when redirect_valid arrives in FETCH without ack in the same cycle.
    - cyc/stb stay high until ack; the returned data is discarded.
    - After that ack, go to FETCH at the new fetch_pc.
- Only one bus cycle is outstanding at a time. Fetch is issued only when a FIFO slot is free, so a push never overflows.
- First fetch: cyc/stb rise in the first cycle after reset deasserts; adr=RESET_PC.
- Latency: ack in cycle M -> instr_valid=1 with that word in cycle M+1 (FIFO registered, no bypass).
- FIFO pop: occurs on instr_valid & instr_ready. Push and pop in the same cycle are allowed and leave occupancy unchanged.
- FIFO pointer wrap-around uses modulo FIFO_DEPTH; a full flag distinguishes full from empty.
- Redirect handling (highest priority after reset):
  - FIFO flushes in the same cycle, so instr_valid=0 next cycle; a simultaneous pop is ignored.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - From IDLE: FETCH next cycle at the new address.
  - In FETCH with ack in the same cycle: ack data discarded, next cycle FETCH at the new address.
  - In FETCH without ack: DRAIN.
  - In DRAIN: the new target overwrites fetch_pc; remain in DRAIN.
- fetch_pc wraps 0xFFFF_FFFC -> 0x0000_0000 with no error.
- Bus errors and timeouts are not handled by this block.

Test Plan:
- ROM model with 1-cycle ack at 0x0=0xDEADBEEF, 0x4=0x12345678; reset for 1 cycle, instr_ready=1 -> adr=0x0 then 0x4; instr_valid with (pc 0x0, 0xDEADBEEF) then (pc 0x4, 0x12345678); no gaps beyond the bus latency.
- instr_ready=0 from reset -> exactly 4 acks (adrs 0x0,0x4,0x8,0xC), then cyc=0. Pulse instr_ready for 1 cycle -> head pc 0x0 popped, one new fetch at adr=0x10.
- redirect_valid with redirect_pc=0x100 while stb is high at adr=0x8 and ack is delayed 3 cycles -> cyc held until ack; word from 0x8 never appears on instr_data; next adr=0x100; first instr_pc after redirect = 0x100.
- redirect_pc=0x00000103 while IDLE with a full FIFO -> FIFO emptied next cycle (instr_valid=0); following bus cycle adr=0x100.
- redirect_valid and instr_ready both high with 2 entries buffered -> both entries discarded, no stale pc presented, fetch resumes at redirect target.
- reset asserted mid-FETCH at adr=0x4 -> cyc=0 the next cycle, instr_valid=0; after release, adr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// wishbone_if: classic Wishbone bus bundle between the instruction fetch
// master and the boot ROM slave.
//   cyc, stb  : bus cycle / strobe (master -> slave)
//   we        : write enable, always 0 for this master
//   sel[3:0]  : byte selects, always 4'hF
//   adr[31:0] : word-aligned byte address
//   dat_i     : read data (slave -> master)
//   ack       : cycle acknowledge (slave -> master)
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic        ack;

  modport master (output cyc, output stb, output we, output sel, output adr,
                  input dat_i, input ack);
  modport slave  (input cyc, input stb, input we, input sel, input adr,
                  output dat_i, output ack);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction prefetcher in front of the boot ROM.
// Issues one Wishbone read at a time from fetch_pc, buffers {pc, word} pairs
// in a FIFO_DEPTH-entry prefetch FIFO and hands them to decode over
// valid/ready. A redirect flushes the FIFO and restarts fetch at a new address.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   wishbone           : Wishbone master (cyc/stb/we/sel/adr out, dat_i/ack in)
//   redirect_valid/_pc : restart fetch at redirect_pc (low 2 bits ignored)
//   instr_valid/ready  : decode handshake on the FIFO head
//   instr_data/pc      : instruction word at the head and its byte address
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  wishbone_if.master  wishbone,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   adr_r;
  logic          cyc_r;

  logic [31:0]   pc_mem_r   [FIFO_DEPTH];
  logic [31:0]   data_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          full_r;

  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] occ_s;
  logic [CW-1:0] occ_after_s;
  logic [31:0]   target_s;
  logic [31:0]   pc_inc_s;

  // Bus outputs come straight from registers; we/sel are fixed for a read-only master.
  assign wishbone.cyc = cyc_r;
  assign wishbone.stb = cyc_r;
  assign wishbone.we  = 1'b0;
  assign wishbone.sel = 4'hF;
  assign wishbone.adr = adr_r;

  // FIFO status, handshake qualifiers and next-address arithmetic.
  always_comb begin
    empty_s  = (wr_ptr_r == rd_ptr_r) && !full_r;
    occ_s    = full_r ? DEPTH_C : {1'b0, AW'(wr_ptr_r - rd_ptr_r)};
    // A redirect flushes the FIFO, so neither a pop nor the returning word counts.
    pop_s    = !empty_s && instr_ready && !redirect_valid;
    push_s   = (state_r == FETCH) && wishbone.ack && !redirect_valid;
    occ_after_s = occ_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    target_s = redirect_pc & 32'hFFFF_FFFC;
    pc_inc_s = fetch_pc_r + 32'd4;
  end

  // Decode-side view of the FIFO head; data/pc read as zero while empty.
  always_comb begin
    instr_valid = !empty_s;
    if (!empty_s) begin
      instr_data = data_mem_r[rd_ptr_r];
      instr_pc   = pc_mem_r[rd_ptr_r];
    end else begin
      instr_data = 32'h0000_0000;
      instr_pc   = 32'h0000_0000;
    end
  end

  // FIFO storage: written only on an accepted ack, no reset needed on the data.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      data_mem_r[wr_ptr_r] <= wishbone.dat_i;
      pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
    end
  end

  // FIFO pointers and full flag; redirect empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
    end else if (redirect_valid) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        full_r <= ((wr_ptr_r + AW'(1)) == rd_ptr_r);
      end else if (pop_s && !push_s) begin
        full_r <= 1'b0;
      end
    end
  end

  // Fetch FSM with registered cyc/stb/adr; one bus cycle outstanding at most.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cyc_r      <= 1'b0;
      adr_r      <= 32'h0000_0000;
      fetch_pc_r <= RESET_PC;
    end else begin
      case (state_r)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc_r <= target_s;
            adr_r      <= target_s;
            cyc_r      <= 1'b1;
            state_r    <= FETCH;
          end else if (occ_s < DEPTH_C) begin
            adr_r   <= fetch_pc_r;
            cyc_r   <= 1'b1;
            state_r <= FETCH;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            fetch_pc_r <= target_s;
            if (wishbone.ack) begin
              // Cycle just completed: drop its data and start the new target.
              adr_r   <= target_s;
              state_r <= FETCH;
            end else begin
              // Cannot abort a classic cycle; wait for its ack and discard it.
              state_r <= DRAIN;
            end
          end else if (wishbone.ack) begin
            fetch_pc_r <= pc_inc_s;
            if (occ_after_s < DEPTH_C) begin
              adr_r <= pc_inc_s;
            end else begin
              cyc_r   <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (redirect_valid) begin
            fetch_pc_r <= target_s;
            if (wishbone.ack) begin
              adr_r   <= target_s;
              state_r <= FETCH;
            end
          end else if (wishbone.ack) begin
            adr_r   <= fetch_pc_r;
            state_r <= FETCH;
          end
        end
        default: begin
          cyc_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a
// Wishbone ROM model whose ack latency can be stretched.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  wishbone_if wb ();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wishbone      (wb),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc)
  );

  int checks   = 0;
  int failures = 0;

  // ROM slave model state
  int          lat;
  int          s_cnt;
  logic        s_ack;
  logic [31:0] s_dat;
  logic [31:0] ack_q[$];

  assign wb.ack   = s_ack;
  assign wb.dat_i = s_dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'hDEAD_BEEF;
    if (a == 32'h0000_0004) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Registered-ack ROM: ack 1 + lat cycles after stb, one-cycle pulse.
  always @(posedge clk) begin
    if (reset || !wb.cyc || !wb.stb) begin
      s_ack <= 1'b0;
      s_cnt <= 0;
    end else if (s_ack) begin
      s_ack <= 1'b0;
      s_cnt <= 0;
    end else if (s_cnt >= lat) begin
      s_ack <= 1'b1;
      s_dat <= rom(wb.adr);
      s_cnt <= 0;
    end else begin
      s_cnt <= s_cnt + 1;
    end
  end

  // Log the address of every completed bus cycle.
  always @(posedge clk) begin
    if (wb.cyc && wb.stb && wb.ack) ack_q.push_back(wb.adr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Tick until instr_valid; n = cycles waited, -1 on timeout (counted as a failure).
  task automatic wait_valid(input string name, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (instr_valid) begin
        n = i;
        break;
      end
    end
    chk({name, "_timeout"}, 32'(n >= 0), 32'd1);
  endtask

  task automatic wait_adr(input string name, input logic [31:0] a, input int max);
    int found;
    found = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (wb.cyc && wb.stb && wb.adr == a) begin
        found = 1;
        break;
      end
    end
    chk({name, "_found"}, 32'(found), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    ack_q.delete();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] pc0;
    logic [31:0] d0;
    logic [31:0] pc1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    instr_ready    = 1'b1;
    lat            = 0;

    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0100_FEFF, 32'h0000_0104, 32'h0104_FEFB};
    vecs[1] = '{32'h0000_0200, 32'h0000_0200, 32'h0200_FDFF, 32'h0000_0204, 32'h0204_FDFB};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFC_0003, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0041, 32'h0000_0040, 32'h0040_FFBF, 32'h0000_0044, 32'h0044_FFBB};

    // Reset state
    tick();
    tick();
    chk("rst_cyc", 32'(wb.cyc), 32'd0);
    chk("rst_stb", 32'(wb.stb), 32'd0);
    chk("rst_we", 32'(wb.we), 32'd0);
    chk("rst_sel", 32'(wb.sel), 32'h0000_000F);
    chk("rst_adr", wb.adr, 32'h0000_0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", instr_data, 32'h0000_0000);
    chk("rst_pc", instr_pc, 32'h0000_0000);

    // Basic sequential fetch with instr_ready=1
    ack_q.delete();
    reset = 1'b0;
    tick();
    chk("first_cyc", 32'(wb.cyc), 32'd1);
    chk("first_adr", wb.adr, 32'h0000_0000);
    wait_valid("w0", 20, n);
    chk("w0_lat", 32'(n), 32'd2);
    chk("w0_pc", instr_pc, 32'h0000_0000);
    chk("w0_data", instr_data, 32'hDEAD_BEEF);
    wait_valid("w1", 20, n);
    chk("w1_lat", 32'(n), 32'd2);
    chk("w1_pc", instr_pc, 32'h0000_0004);
    chk("w1_data", instr_data, 32'h1234_5678);
    chk("w_acks", 32'(ack_q.size() >= 2), 32'd1);
    if (ack_q.size() >= 2) begin
      chk("w_ack0", ack_q[0], 32'h0000_0000);
      chk("w_ack1", ack_q[1], 32'h0000_0004);
    end

    // FIFO fills with instr_ready=0, then a single pop frees one slot
    instr_ready = 1'b0;
    do_reset();
    repeat (30) tick();
    chk("fill_nacks", 32'(ack_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++) begin
      chk($sformatf("fill_adr%0d", i), ack_q[i], 32'(4 * i));
    end
    chk("fill_cyc", 32'(wb.cyc), 32'd0);
    chk("fill_valid", 32'(instr_valid), 32'd1);
    chk("fill_pc", instr_pc, 32'h0000_0000);
    chk("fill_data", instr_data, 32'hDEAD_BEEF);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("pop_pc", instr_pc, 32'h0000_0004);
    repeat (20) tick();
    chk("refill_nacks", 32'(ack_q.size()), 32'd5);
    if (ack_q.size() >= 5) chk("refill_adr", ack_q[4], 32'h0000_0010);
    chk("refill_cyc", 32'(wb.cyc), 32'd0);
    chk("refill_pc", instr_pc, 32'h0000_0004);

    // Redirect while IDLE with a full FIFO; low address bits dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("ridle_valid", 32'(instr_valid), 32'd0);
    chk("ridle_cyc", 32'(wb.cyc), 32'd1);
    chk("ridle_adr", wb.adr, 32'h0000_0100);
    instr_ready = 1'b1;
    wait_valid("ridle_w", 20, n);
    chk("ridle_pc", instr_pc, 32'h0000_0100);
    chk("ridle_data", instr_data, 32'h0100_FEFF);

    // Redirect during a stretched bus cycle at 0x8: DRAIN then restart
    do_reset();
    wait_adr("drain_a8", 32'h0000_0008, 40);
    lat            = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("drain_valid", 32'(instr_valid), 32'd0);
    chk("drain_cyc", 32'(wb.cyc), 32'd1);
    chk("drain_adr", wb.adr, 32'h0000_0008);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drain_hold_cyc%0d", i), 32'(wb.cyc), 32'd1);
      chk($sformatf("drain_hold_adr%0d", i), wb.adr, 32'h0000_0008);
    end
    lat = 0;
    wait_valid("drain_w", 20, n);
    chk("drain_pc", instr_pc, 32'h0000_0100);
    chk("drain_data", instr_data, 32'h0100_FEFF);
    if (ack_q.size() >= 2) begin
      chk("drain_ack_last", ack_q[ack_q.size() - 1], 32'h0000_0100);
      chk("drain_ack_prev", ack_q[ack_q.size() - 2], 32'h0000_0008);
    end else begin
      chk("drain_nacks", 32'(ack_q.size() >= 2), 32'd1);
    end

    // Redirect together with instr_ready while two entries are buffered
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 40 && ack_q.size() < 2; i++) tick();
    chk("two_nacks", 32'(ack_q.size()), 32'd2);
    chk("two_valid", 32'(instr_valid), 32'd1);
    chk("two_pc", instr_pc, 32'h0000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("two_flush_valid", 32'(instr_valid), 32'd0);
    wait_valid("two_w", 20, n);
    chk("two_new_pc", instr_pc, 32'h0000_0300);
    chk("two_new_data", instr_data, 32'h0300_FCFF);

    // Table of redirect targets, including alignment and address wrap
    for (int v = 0; v < 4; v++) begin
      redirect_valid = 1'b1;
      redirect_pc    = vecs[v].rpc;
      tick();
      redirect_valid = 1'b0;
      chk($sformatf("tv%0d_flush", v), 32'(instr_valid), 32'd0);
      wait_valid($sformatf("tv%0d_w0", v), 20, n);
      chk($sformatf("tv%0d_pc0", v), instr_pc, vecs[v].pc0);
      chk($sformatf("tv%0d_d0", v), instr_data, vecs[v].d0);
      wait_valid($sformatf("tv%0d_w1", v), 20, n);
      chk($sformatf("tv%0d_pc1", v), instr_pc, vecs[v].pc1);
      chk($sformatf("tv%0d_d1", v), instr_data, vecs[v].d1);
    end

    // Reset in the middle of the fetch at 0x4
    do_reset();
    wait_adr("mid_a4", 32'h0000_0004, 40);
    reset = 1'b1;
    tick();
    chk("mid_cyc", 32'(wb.cyc), 32'd0);
    chk("mid_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_restart_cyc", 32'(wb.cyc), 32'd1);
    chk("mid_restart_adr", wb.adr, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
